// File: rtl/cmult_arbiter.sv
// cmult_arbiter: shares one pipelined complex multiplier among NREQ requesters, returning ID-tagged products.
// Define CMULT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module cmult_arbiter #(
    parameter int WL       = 16,
    parameter int NREQ     = 4,
    parameter int MULT_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WL-1:0]      req_a_r,
    input  logic [NREQ*WL-1:0]      req_a_i,
    input  logic [NREQ*WL-1:0]      req_b_r,
    input  logic [NREQ*WL-1:0]      req_b_i,
    output logic                    mul_in_valid,
    output logic [WL-1:0]           mul_a_r,
    output logic [WL-1:0]           mul_a_i,
    output logic [WL-1:0]           mul_b_r,
    output logic [WL-1:0]           mul_b_i,
    input  logic [WL-1:0]           mul_out_r,
    input  logic [WL-1:0]           mul_out_i,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WL-1:0]           rsp_r,
    output logic [WL-1:0]           rsp_i
);
    localparam int IDW = $clog2(NREQ);

    logic                       gnt_vld;
    logic [IDW-1:0]             gnt_id;
    logic [MULT_LAT:0]          tag_vld_q, tag_vld_d;
    logic [MULT_LAT:0][IDW-1:0] tag_id_q, tag_id_d;
    logic [4*WL-1:0]            ops_q, ops_d;

`ifdef CMULT_ARB_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;

    // Scan downwards so the requester closest to ptr_q is the last writer and wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (!rst && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
        ptr_d = gnt_vld ? IDW'((int'(gnt_id) + 1) % NREQ) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (!rst && req_valid[k]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(k);
            end
        end
    end
`endif

    always_comb begin
        tag_vld_d = {tag_vld_q[MULT_LAT-1:0], gnt_vld};
        tag_id_d  = {tag_id_q[MULT_LAT-1:0], gnt_id};
        ops_d     = gnt_vld ? {req_a_r[int'(gnt_id)*WL +: WL], req_a_i[int'(gnt_id)*WL +: WL],
                               req_b_r[int'(gnt_id)*WL +: WL], req_b_i[int'(gnt_id)*WL +: WL]} : ops_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            ops_q     <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            ops_q     <= ops_d;
        end
    end

    assign req_ready    = NREQ'(gnt_vld) << gnt_id;
    assign mul_in_valid = tag_vld_q[0];
    assign {mul_a_r, mul_a_i, mul_b_r, mul_b_i} = ops_q;
    // The tag tail lines up with the multiplier output, so data passes straight through.
    assign rsp_valid    = NREQ'(tag_vld_q[MULT_LAT]) << tag_id_q[MULT_LAT];
    assign rsp_id       = tag_vld_q[MULT_LAT] ? tag_id_q[MULT_LAT] : '0;
    assign rsp_r        = mul_out_r;
    assign rsp_i        = mul_out_i;
endmodule
